// File: rtl/ex_alu_issue.sv
// ex_alu_issue: ID/EX pipeline register, ALU-control decode, operand
// forwarding and beq resolution for the execute stage.
// Optional feature macro: EX_ILLEGAL_FUNCT_EN adds the illegal_op output,
// flagging valid instructions whose decode lands on the 1111 opcode.
module ex_alu_issue #(
  parameter int WORD = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [1:0]      id_alu_op,
  input  logic [5:0]      id_funct,
  input  logic            id_alu_src,
  input  logic            id_branch,
  input  logic [WORD-1:0] id_rs_data,
  input  logic [WORD-1:0] id_rt_data,
  input  logic [WORD-1:0] id_imm,
  input  logic [1:0]      forward_a,
  input  logic [1:0]      forward_b,
  input  logic [WORD-1:0] exmem_result,
  input  logic [WORD-1:0] memwb_result,
  input  logic            alu_zero,
  output logic            ex_valid,
  output logic [WORD-1:0] alu_a,
  output logic [WORD-1:0] alu_b,
  output logic [3:0]      alu_control,
  output logic [WORD-1:0] ex_store_data,
  output logic            branch_taken
`ifdef EX_ILLEGAL_FUNCT_EN
  ,
  output logic            illegal_op
`endif
);

  typedef struct packed {
    logic            valid;
    logic            branch;
    logic            alu_src;
    logic            illegal;
    logic [3:0]      ctrl;
    logic [WORD-1:0] rs;
    logic [WORD-1:0] rt;
    logic [WORD-1:0] imm;
  } idex_t;

  idex_t      idex_d, idex_q;
  logic [3:0] dec_ctrl;
  logic [WORD-1:0] fwd_a, fwd_b;

  // ALU-control decode from main-decoder ALUOp and funct
  always_comb begin
    dec_ctrl = 4'b1111;
    unique case (id_alu_op)
      2'b00: dec_ctrl = 4'b0010;
      2'b01: dec_ctrl = 4'b0110;
      2'b10: begin
        unique case (id_funct)
          6'b100000: dec_ctrl = 4'b0010;
          6'b100010: dec_ctrl = 4'b0110;
          6'b100100: dec_ctrl = 4'b0000;
          6'b100101: dec_ctrl = 4'b0001;
          6'b101010: dec_ctrl = 4'b0111;
          default:   dec_ctrl = 4'b1111;
        endcase
      end
      default: dec_ctrl = 4'b1111;
    endcase
  end

  // Next ID/EX contents: flush inserts a bubble and wins over stall
  always_comb begin
    idex_d = idex_q;
    if (flush) begin
      idex_d = '0;
    end else if (!stall) begin
      idex_d.valid   = id_valid;
      idex_d.branch  = id_branch;
      idex_d.alu_src = id_alu_src;
      idex_d.illegal = id_valid & (dec_ctrl == 4'b1111);
      idex_d.ctrl    = dec_ctrl;
      idex_d.rs      = id_rs_data;
      idex_d.rt      = id_rt_data;
      idex_d.imm     = id_imm;
    end
  end

  // ID/EX register with synchronous reset overriding everything
  always_ff @(posedge clk) begin
    if (reset) idex_q <= '0;
    else       idex_q <= idex_d;
  end

  // Forwarding muxes and operand/branch outputs; 11 falls back to the register
  always_comb begin
    unique case (forward_a)
      2'b10:   fwd_a = exmem_result;
      2'b01:   fwd_a = memwb_result;
      default: fwd_a = idex_q.rs;
    endcase
    unique case (forward_b)
      2'b10:   fwd_b = exmem_result;
      2'b01:   fwd_b = memwb_result;
      default: fwd_b = idex_q.rt;
    endcase
    ex_valid      = idex_q.valid;
    alu_control   = idex_q.ctrl;
    alu_a         = fwd_a;
    alu_b         = idex_q.alu_src ? idex_q.imm : fwd_b;
    ex_store_data = fwd_b;
    branch_taken  = idex_q.valid & idex_q.branch & alu_zero;
  end

`ifdef EX_ILLEGAL_FUNCT_EN
  assign illegal_op = idex_q.illegal;
`else
  logic unused_illegal;
  assign unused_illegal = idex_q.illegal;
`endif

endmodule

// File: tb/tb_ex_alu_issue.sv
// Directed self-checking bench for ex_alu_issue.
module tb_ex_alu_issue;
  localparam int WORD = 32;

  logic            clk = 1'b0;
  logic            reset, stall, flush, id_valid, id_alu_src, id_branch, alu_zero;
  logic [1:0]      id_alu_op, forward_a, forward_b;
  logic [5:0]      id_funct;
  logic [WORD-1:0] id_rs_data, id_rt_data, id_imm, exmem_result, memwb_result;
  logic            ex_valid, branch_taken;
  logic [WORD-1:0] alu_a, alu_b, ex_store_data;
  logic [3:0]      alu_control;
`ifdef EX_ILLEGAL_FUNCT_EN
  logic            illegal_op;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  ex_alu_issue #(.WORD(WORD)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_alu_op(id_alu_op), .id_funct(id_funct),
    .id_alu_src(id_alu_src), .id_branch(id_branch),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .forward_a(forward_a), .forward_b(forward_b),
    .exmem_result(exmem_result), .memwb_result(memwb_result),
    .alu_zero(alu_zero), .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b),
    .alu_control(alu_control), .ex_store_data(ex_store_data),
    .branch_taken(branch_taken)
`ifdef EX_ILLEGAL_FUNCT_EN
    , .illegal_op(illegal_op)
`endif
  );

  always #5 clk = ~clk;

  // advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_id(input logic v, input logic [1:0] op, input logic [5:0] fn,
                         input logic src, input logic br,
                         input logic [WORD-1:0] rs, input logic [WORD-1:0] rt,
                         input logic [WORD-1:0] imm);
    id_valid = v; id_alu_op = op; id_funct = fn; id_alu_src = src; id_branch = br;
    id_rs_data = rs; id_rt_data = rt; id_imm = imm;
  endtask

  task automatic test_reset();
    stall = 0; flush = 0; forward_a = 2'b00; forward_b = 2'b00; alu_zero = 1;
    exmem_result = 32'hdead_beef; memwb_result = 32'hcafe_f00d;
    reset = 1;
    for (int i = 0; i < 2; i++) begin
      load_id(1'b1, 2'($urandom), 6'($urandom), 1'($urandom), 1'b1,
              $urandom, $urandom, $urandom);
      tick();
    end
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", ex_valid); end
    n_checks++; if (alu_control !== 4'b0000) begin n_fail++; $display("FAIL reset_ctrl got %b want 0000", alu_control); end
    n_checks++; if (branch_taken !== 1'b0) begin n_fail++; $display("FAIL reset_branch got %b want 0", branch_taken); end
    n_checks++; if (alu_a !== 0 || alu_b !== 0 || ex_store_data !== 0) begin
      n_fail++; $display("FAIL reset_operands got a=%h b=%h sd=%h want 0", alu_a, alu_b, ex_store_data); end
    reset = 0;
  endtask

  task automatic test_rtype();
    logic [5:0] fn [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
    logic [3:0] ex [6] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1111};
    for (int i = 0; i < 6; i++) begin
      load_id(1'b1, 2'b10, fn[i], 1'b0, 1'b0, 0, 0, 0);
      tick();
      n_checks++; if (alu_control !== ex[i] || ex_valid !== 1'b1) begin
        n_fail++; $display("FAIL rtype_%0d got ctrl=%b v=%b want ctrl=%b v=1", i, alu_control, ex_valid, ex[i]); end
    end
    // reserved ALUOp and a non-valid load both still update alu_control
    load_id(1'b1, 2'b11, 6'b100000, 1'b0, 1'b0, 0, 0, 0); tick();
    n_checks++; if (alu_control !== 4'b1111) begin n_fail++; $display("FAIL aluop11 got %b want 1111", alu_control); end
    load_id(1'b0, 2'b01, 6'b0, 1'b0, 1'b0, 0, 0, 0); tick();
    n_checks++; if (alu_control !== 4'b0110 || ex_valid !== 1'b0) begin
      n_fail++; $display("FAIL invalid_load got ctrl=%b v=%b want 0110 v=0", alu_control, ex_valid); end
  endtask

  task automatic test_forwarding();
    load_id(1'b1, 2'b00, 6'b0, 1'b0, 1'b0, 32'd5, 32'd7, 32'h10); tick();
    n_checks++; if (alu_a !== 32'd5 || alu_b !== 32'd7 || ex_store_data !== 32'd7) begin
      n_fail++; $display("FAIL fwd_none got a=%h b=%h sd=%h want 5 7 7", alu_a, alu_b, ex_store_data); end
    exmem_result = 32'h20; memwb_result = 32'h30;
    forward_a = 2'b10; #1;
    n_checks++; if (alu_a !== 32'h20) begin n_fail++; $display("FAIL fwd_a_exmem got %h want 20", alu_a); end
    forward_a = 2'b01; #1;
    n_checks++; if (alu_a !== 32'h30) begin n_fail++; $display("FAIL fwd_a_memwb got %h want 30", alu_a); end
    forward_a = 2'b11; #1;
    n_checks++; if (alu_a !== 32'd5) begin n_fail++; $display("FAIL fwd_a_11 got %h want 5", alu_a); end
    forward_b = 2'b01; #1;
    n_checks++; if (alu_b !== 32'h30 || ex_store_data !== 32'h30) begin
      n_fail++; $display("FAIL fwd_b_memwb got b=%h sd=%h want 30 30", alu_b, ex_store_data); end
    forward_b = 2'b10; #1;
    n_checks++; if (alu_b !== 32'h20 || ex_store_data !== 32'h20) begin
      n_fail++; $display("FAIL fwd_b_exmem got b=%h sd=%h want 20 20", alu_b, ex_store_data); end
    forward_b = 2'b01;
    load_id(1'b1, 2'b00, 6'b0, 1'b1, 1'b0, 32'd5, 32'd7, 32'h10); tick();
    n_checks++; if (alu_b !== 32'h10 || ex_store_data !== 32'h30) begin
      n_fail++; $display("FAIL alu_src got b=%h sd=%h want 10 30", alu_b, ex_store_data); end
    forward_b = 2'b11; #1;
    n_checks++; if (alu_b !== 32'h10 || ex_store_data !== 32'd7) begin
      n_fail++; $display("FAIL alu_src_reg got b=%h sd=%h want 10 7", alu_b, ex_store_data); end
    forward_a = 2'b00; forward_b = 2'b00;
  endtask

  task automatic test_stall_flush();
    load_id(1'b1, 2'b00, 6'b0, 1'b0, 1'b0, 32'd1, 32'd2, 0); tick();
    load_id(1'b1, 2'b01, 6'b0, 1'b0, 1'b0, 32'd9, 32'd9, 0);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (alu_control !== 4'b0010 || alu_a !== 32'd1 || ex_valid !== 1'b1) begin
        n_fail++; $display("FAIL stall_%0d got ctrl=%b a=%h v=%b want 0010 1 1", i, alu_control, alu_a, ex_valid); end
    end
    flush = 1; tick();
    n_checks++; if (ex_valid !== 1'b0 || alu_control !== 4'b0000 || alu_a !== 0) begin
      n_fail++; $display("FAIL flush_over_stall got v=%b ctrl=%b a=%h want 0 0000 0", ex_valid, alu_control, alu_a); end
    flush = 0; stall = 0;
    load_id(1'b1, 2'b01, 6'b0, 1'b0, 1'b0, 32'd3, 32'd4, 0); tick();
    stall = 1; reset = 1; tick();
    n_checks++; if (ex_valid !== 1'b0 || alu_control !== 4'b0000 || alu_a !== 0) begin
      n_fail++; $display("FAIL reset_in_stall got v=%b ctrl=%b a=%h want 0 0000 0", ex_valid, alu_control, alu_a); end
    reset = 0; stall = 0;
  endtask

  task automatic test_branch();
    load_id(1'b1, 2'b01, 6'b0, 1'b0, 1'b1, 32'd4, 32'd4, 0); tick();
    alu_zero = 1; #1;
    n_checks++; if (branch_taken !== 1'b1 || alu_control !== 4'b0110) begin
      n_fail++; $display("FAIL beq_taken got bt=%b ctrl=%b want 1 0110", branch_taken, alu_control); end
    alu_zero = 0; #1;
    n_checks++; if (branch_taken !== 1'b0) begin n_fail++; $display("FAIL beq_not_taken got %b want 0", branch_taken); end
    load_id(1'b0, 2'b01, 6'b0, 1'b0, 1'b1, 32'd4, 32'd4, 0); alu_zero = 1; tick();
    n_checks++; if (branch_taken !== 1'b0) begin n_fail++; $display("FAIL beq_invalid got %b want 0", branch_taken); end
    load_id(1'b1, 2'b01, 6'b0, 1'b0, 1'b0, 32'd4, 32'd4, 0); tick();
    n_checks++; if (branch_taken !== 1'b0) begin n_fail++; $display("FAIL nonbranch_zero got %b want 0", branch_taken); end
    load_id(1'b1, 2'b01, 6'b0, 1'b0, 1'b1, 32'd4, 32'd4, 0); flush = 1; tick();
    n_checks++; if (branch_taken !== 1'b0) begin n_fail++; $display("FAIL bubble_branch got %b want 0", branch_taken); end
    flush = 0; alu_zero = 0;
  endtask

`ifdef EX_ILLEGAL_FUNCT_EN
  task automatic test_illegal();
    load_id(1'b1, 2'b10, 6'b001000, 1'b0, 1'b0, 0, 0, 0); tick();
    n_checks++; if (illegal_op !== 1'b1) begin n_fail++; $display("FAIL illegal_set got %b want 1", illegal_op); end
    load_id(1'b1, 2'b00, 6'b0, 1'b0, 1'b0, 0, 0, 0); stall = 1; tick();
    n_checks++; if (illegal_op !== 1'b1) begin n_fail++; $display("FAIL illegal_hold got %b want 1", illegal_op); end
    stall = 0; flush = 1; tick();
    n_checks++; if (illegal_op !== 1'b0) begin n_fail++; $display("FAIL illegal_flush got %b want 0", illegal_op); end
    flush = 0;
    load_id(1'b0, 2'b10, 6'b001000, 1'b0, 1'b0, 0, 0, 0); tick();
    n_checks++; if (illegal_op !== 1'b0) begin n_fail++; $display("FAIL illegal_invalid got %b want 0", illegal_op); end
  endtask
`endif

  initial begin
    test_reset();
    test_rtype();
    test_forwarding();
    test_stall_flush();
    test_branch();
`ifdef EX_ILLEGAL_FUNCT_EN
    test_illegal();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ex_alu_issue.md
Name: ex_alu_issue

Overview:
- ID/EX pipeline register plus ALU-control decode and operand forwarding for the MIPS pipeline.
- Produces the `alu_a`, `alu_b` and 4-bit `alu_control` inputs consumed by the execute-stage ALU.
- Consumes the ALU `zero` flag back to resolve beq.
- Handles stall (hold) and flush (bubble insertion) from the hazard unit.

Parameters:
- WORD, 32, datapath width of operands, immediates and forwarded results.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold ID/EX contents
- flush  in  1  load a bubble into ID/EX
- id_valid  in  1  ID stage holds a real instruction
- id_alu_op  in  2  main-decoder ALUOp: 00 add, 01 sub, 10 use funct, 11 reserved
- id_funct  in  6  instruction funct field
- id_alu_src  in  1  1 = operand B is immediate
- id_branch  in  1  instruction is beq
- id_rs_data  in  WORD  register-file rs value
- id_rt_data  in  WORD  register-file rt value
- id_imm  in  WORD  sign-extended immediate
- forward_a  in  2  operand A source: 00 reg, 10 EX/MEM, 01 MEM/WB, 11 reg
- forward_b  in  2  operand B (pre-ALUSrc) source, same encoding
- exmem_result  in  WORD  EX/MEM forwarded value
- memwb_result  in  WORD  MEM/WB forwarded value
- alu_zero  in  1  ALU zero flag
- ex_valid  out  1  EX stage holds a real instruction
- alu_a  out  WORD  ALU operand a
- alu_b  out  WORD  ALU operand b
- alu_control  out  4  ALU opcode
- ex_store_data  out  WORD  forwarded rt value for sw
- branch_taken  out  1  beq resolved taken

Behaviour:
- Register update priority on posedge clk: reset > flush > stall > load.
- **reset:** every stored field is 0, i.e. ex_valid=0, alu_control=4'b0000, branch=0, alu_src=0, rs/rt/imm=0. Consequences:
  - alu_a=alu_b=ex_store_data=0 when forward selects are 00.
  - branch_taken=0.
- **flush:** same contents as reset (bubble). Flush beats stall when both are asserted in the same cycle.
- **stall (without flush):** all registers hold. Outputs change only through the combinational forwarding inputs.
- **load:**
  - Latch id_valid, id_branch, id_alu_src, id_rs_data, id_rt_data, id_imm.
  - Latch the decoded control: 00→0010 add, 01→0110 sub, 11→1111.
  - For 10, decode funct: 100000→0010, 100010→0110, 100100→0000, 100101→0001, 101010→0111; any other funct→1111. The ALU returns 0 for 1111.
- Latency: exactly one cycle from ID inputs to registered alu_control/operands. No internal pipelining beyond that.
- **Operand forwarding (combinational, after the register):**
  - fwd_a = forward_a 10 ? exmem_result : 01 ? memwb_result : reg rs. Encoding 11 behaves as 00.
  - fwd_b is formed the same way from reg rt and forward_b.
  - alu_a = fwd_a.
  - alu_b = reg alu_src ? reg imm : fwd_b.
  - ex_store_data = fwd_b, independent of alu_src.
- **Branch:** branch_taken = ex_valid & reg branch & alu_zero (combinational, same cycle as the ALU result).
  - Bubbles never produce branch_taken=1.
  - Non-branch instructions never produce branch_taken=1, even with alu_zero=1.
- alu_control is updated on load even when id_valid=0. ex_valid=0 marks the result as don't-care downstream.
- Reset asserted mid-stall clears the register. The stall is ignored that cycle.

Optional Feature:
- Macro: EX_ILLEGAL_FUNCT_EN.
- With the macro defined:
  - Extra output illegal_op (1 bit), reset/flush value 0.
  - Registered on load: set to id_valid & (decoded control == 1111). Holds under stall.
- Without the macro: the port is absent; 1111 decode still occurs silently.

Test Plan:
- **Reset:** reset=1 for 2 cycles with id_* random → ex_valid=0, alu_control=0000, branch_taken=0, alu_a=alu_b=0 (forward 00).
- **R-type decode:** id_alu_op=10 with funct 100000/100010/100100/100101/101010/000000 on successive cycles, stall=flush=0 → alu_control next cycle 0010/0110/0000/0001/0111/1111.
- **Forwarding:** load rs=5, rt=7, imm=0x10, alu_src=0. Then:
  - forward_a=10 with exmem_result=0x20 → alu_a=0x20.
  - forward_b=01 with memwb_result=0x30 → alu_b=0x30, ex_store_data=0x30.
  - Set alu_src=1 on a new load → alu_b=0x10, ex_store_data remains fwd_b.
- **Stall/flush:**
  - Load an add (ALUOp 00), then stall=1 for 3 cycles while id_alu_op=01 → alu_control stays 0010.
  - Assert stall=1 and flush=1 together → next cycle ex_valid=0, alu_control=0000.
- **Branch:**
  - beq loaded (alu_op 01, branch 1, valid 1), alu_zero=1 → branch_taken=1, alu_control=0110.
  - alu_zero=0 → branch_taken=0.
  - Same with id_valid=0 → branch_taken=0.
- **With EX_ILLEGAL_FUNCT_EN:**
  - funct 001000, alu_op 10, valid 1 → illegal_op=1 next cycle.
  - Flush → illegal_op=0.
